gray_count_decoder: RTL
=======================

// Module: gray_count_decoder
// PURPOSE
//  Receiving end of the Gray-coded counter path: samples a Gray count word
//  (GrayCounter output), passes it through a flop synchroniser, decodes it to
//  binary and checks every step. Used wherever a Gray pointer/count is
//  consumed, e.g. FIFO read side and counter monitors. Flags illegal jumps.
// PARAMETERS
//  BIT_SIZE     4  width of the Gray input and binary output
//  SYNC_STAGES  2  synchroniser depth, legal range >= 2
//  ERR_W        8  width of the saturating error counter
// PORTS
//  clk_i        in   1            single clock, all logic on posedge
//  rst_i        in   1            asynchronous, active-low reset
//  gray_i       in   BIT_SIZE     Gray-coded count from the sending counter
//  clr_err_i    in   1            synchronous clear of err_cnt_o
//  bin_o        out  BIT_SIZE     decoded binary count, registered
//  bin_valid_o  out  1            bin_o holds a sample that has gone through the full pipeline
//  delta_o      out  BIT_SIZE     bin_o minus previous bin_o, mod 2^BIT_SIZE
//  step_err_o   out  1            1-cycle pulse on an illegal step
//  err_cnt_o    out  ERR_W        saturating count of step errors
// BEHAVIOUR
//  - Reset (rst_i=0, asynchronous): all flops to 0.
//    bin_o=0, bin_valid_o=0, delta_o=0, step_err_o=0, err_cnt_o=0.
//  - Pipeline: SYNC_STAGES flops on gray_i.
//    Then 1 decode register: bin[i] = ^(sync_gray >> i).
//    Latency from gray_i to bin_o is SYNC_STAGES+1 posedges.
//  - bin_valid_o: valid shift register, depth SYNC_STAGES+1, fed with 1.
//    Rises on the (SYNC_STAGES+1)th posedge after reset release.
//    Stays high until the next reset.
//  - Step check uses the previous registered bin_o (prev) and the new decoded value (next).
//    delta = next - prev, BIT_SIZE-bit modular; registered into delta_o with bin_o.
//    Legal step: delta is 0 (hold) or 1 (increment).
//    Wrap from 2^BIT_SIZE-1 to 0 gives delta 1 and is legal.
//    Any other delta, including backward steps, is illegal: step_err_o pulses
//    for exactly one cycle, aligned with the bin_o update.
//  - The first valid sample after reset is never checked: step_err_o stays 0
//    and delta_o stays 0. Checking starts with the second valid sample.
//  - err_cnt_o: +1 per step_err pulse, saturates at 2^ERR_W-1 and does not wrap.
//    clr_err_i alone loads 0.
//    clr_err_i together with a new error loads 1 (clear first, then count).
//  - Reset mid-stream: outputs go to 0 immediately and the pipeline refills.
//    The unchecked-first-sample rule applies again.
//  - No back-pressure; one sample per clock, every clock.
// STRUCTURE
//  - Package gray_pkg:
//    function gray2bin(logic [W-1:0]) and function bin2gray (shared with GrayCounter);
//    localparam ERR_W_DEFAULT=8.
//  - Sub-module gray_sync: SYNC_STAGES-deep flop chain, BIT_SIZE wide,
//    asynchronous active-low reset, parameters BIT_SIZE and SYNC_STAGES.
//  - Top level: gray_sync, decode register, valid shift register,
//    delta/err logic, saturating counter.
// TESTING (BIT_SIZE=4, SYNC_STAGES=2, latency 3)
//  1. Release reset, drive Gray 0,1,3,2,6,7 on successive clocks ->
//     bin_o 0,1,2,3,4,5 three clocks later; bin_valid_o high on 3rd edge;
//     delta_o 0 then 1 each step; no errors.
//  2. Drive Gray 4'b1000 then 4'b0000 -> bin_o 15 then 0, delta_o=1,
//     step_err_o stays 0 (legal wrap).
//  3. Drive Gray 4'b0001 then 4'b0110 -> bin_o 1 then 4, delta_o=3,
//     step_err_o one-cycle pulse, err_cnt_o=1.
//  4. Hold gray_i=4'b0011 for 5 clocks -> bin_o=2, delta_o=0, no error;
//     then Gray 4'b0001 (bin 1) -> delta_o=15, error (backward step).
//  5. Inject 300 illegal steps -> err_cnt_o=255, held;
//     assert clr_err_i in the same cycle as a new error -> err_cnt_o=1.
//  6. Assert rst_i low mid-sequence, between clock edges -> all outputs 0
//     with no clock edge; after release bin_valid_o returns on the 3rd edge;
//     a first sample of Gray 4'b0110 gives no error.

Source files
------------

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared Gray/binary conversion helpers and defaults
`timescale 1ns/1ps
package gray_pkg;

    // Helpers work on a fixed maximum width; callers zero-extend on the way in
    // and truncate on the way out. Leading zeros do not change either mapping.
    localparam int GRAY_MAX_W    = 32;
    localparam int ERR_W_DEFAULT = 8;

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-stage flop synchroniser for a Gray-coded word
// Ports:
//   clk_i  - clock, all flops on posedge
//   rst_i  - asynchronous active-low reset, clears every stage
//   d_i    - Gray word from the sending domain
//   q_o    - synchronised Gray word, SYNC_STAGES posedges after d_i
`timescale 1ns/1ps
module gray_sync #(
    parameter int BIT_SIZE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BIT_SIZE-1:0] d_i,
    output logic [BIT_SIZE-1:0] q_o
);

    logic [SYNC_STAGES-1:0][BIT_SIZE-1:0] sync_q;
    logic [SYNC_STAGES-1:0][BIT_SIZE-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/gray_count_decoder.sv
// rtl/gray_count_decoder.sv - synchronise, decode and step-check a Gray count
// Ports:
//   clk_i       - clock, all logic on posedge
//   rst_i       - asynchronous active-low reset
//   gray_i      - Gray-coded count from the sending counter
//   clr_err_i   - synchronous clear of err_cnt_o
//   bin_o       - decoded binary count, registered
//   bin_valid_o - bin_o holds a sample that has passed the whole pipeline
//   delta_o     - bin_o minus previous bin_o, modulo 2^BIT_SIZE
//   step_err_o  - one-cycle pulse when a step is neither hold nor +1
//   err_cnt_o   - saturating count of step errors
`timescale 1ns/1ps
module gray_count_decoder
    import gray_pkg::*;
#(
    parameter int BIT_SIZE    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ERR_W       = ERR_W_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BIT_SIZE-1:0] gray_i,
    input  logic                clr_err_i,
    output logic [BIT_SIZE-1:0] bin_o,
    output logic                bin_valid_o,
    output logic [BIT_SIZE-1:0] delta_o,
    output logic                step_err_o,
    output logic [ERR_W-1:0]    err_cnt_o
);

    logic [BIT_SIZE-1:0] sync_gray;
    logic [BIT_SIZE-1:0] bin_next;
    logic [BIT_SIZE-1:0] step_raw;
    logic                check_en;

    logic [BIT_SIZE-1:0] bin_q, bin_d;
    logic [SYNC_STAGES:0] vld_q, vld_d;
    logic [BIT_SIZE-1:0] delta_q, delta_d;
    logic                step_err_q, step_err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    gray_sync #(
        .BIT_SIZE    (BIT_SIZE),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (gray_i),
        .q_o   (sync_gray)
    );

    assign bin_next = BIT_SIZE'(gray2bin(GRAY_MAX_W'(sync_gray)));
    assign step_raw = bin_next - bin_q;

    // vld_q[SYNC_STAGES-1] marks the sample about to be loaded into bin_q as
    // valid; vld_q[SYNC_STAGES] marks the current bin_q as valid. Both must be
    // set for a step to exist, so the first valid sample is never checked.
    assign check_en = vld_q[SYNC_STAGES-1] & vld_q[SYNC_STAGES];

    always_comb begin
        vld_d      = {vld_q[SYNC_STAGES-1:0], 1'b1};
        bin_d      = bin_next;
        delta_d    = '0;
        step_err_d = 1'b0;
        err_cnt_d  = err_cnt_q;

        if (check_en) begin
            delta_d    = step_raw;
            step_err_d = (step_raw > BIT_SIZE'(1));
        end

        // Clear takes effect first, then a coincident error counts from zero.
        if (clr_err_i) begin
            err_cnt_d = step_err_d ? ERR_W'(1) : '0;
        end else if (step_err_d && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_q      <= '0;
            bin_q      <= '0;
            delta_q    <= '0;
            step_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            vld_q      <= vld_d;
            bin_q      <= bin_d;
            delta_q    <= delta_d;
            step_err_q <= step_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bin_o       = bin_q;
    assign bin_valid_o = vld_q[SYNC_STAGES];
    assign delta_o     = delta_q;
    assign step_err_o  = step_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule
